mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 162 ++++++++++++++++
 tb/tb_mem_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder
//   Single-port word memory behind a request/ready handshake with a fixed,
//   parameterised response latency. A request is latched in IDLE. The FSM
//   then counts down in WAIT and spends one RESPOND cycle with ready high.
//   Writes commit on the edge that ends RESPOND. Reads present their word in
//   RESPOND and hold it until the next read completes.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 16-bit words (default 8)
//   LATENCY    : cycles from acceptance to ready, 1..15 (default 2)
//
// Ports
//   clk      in   1  clock, rising edge
//   reset    in   1  synchronous active-high reset
//   memread  in   1  read request
//   memwrite in   1  write request
//   address  in  16  word address
//   datain   in  16  write data
//   dataout  out 16  read data (held between reads)
//   ready    out  1  one-cycle completion strobe
//   busy     out  1  high while a request is in flight
//   error    out  1  one-cycle strobe: conflicting request or out-of-range access
`timescale 1ns/1ps

module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] address,
  input  logic [15:0] datain,
  output logic [15:0] dataout,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    op_write_q, op_write_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [15:0]             data_q, data_d;
  logic                    oob_q, oob_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    error_q, error_d;
  logic [15:0]             dataout_q;

  logic                    accept;
  logic                    conflict;
  logic                    rd_en;
  logic                    wr_en;

  logic [15:0]             mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    oob_d      = oob_q;

    accept   = (state_q == S_IDLE) && (memread ^ memwrite);
    conflict = (state_q == S_IDLE) && memread && memwrite;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_write_d = memwrite;
          addr_d     = address[DEPTH_LOG2-1:0];
          data_d     = datain;
          // Any address bit above the array index makes the access out of range.
          oob_d      = |(address >> DEPTH_LOG2);
          cnt_d      = CNT_LOAD;
          state_d    = (LATENCY == 1) ? S_RESPOND : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    ready_d = (state_d == S_RESPOND);
    busy_d  = (state_d != S_IDLE);
    error_d = conflict || ((state_d == S_RESPOND) && oob_d);

    // The array read is issued on the edge that enters RESPOND. addr_d already
    // carries the incoming address when LATENCY=1 jumps straight from IDLE.
    rd_en = (state_d == S_RESPOND) && !op_write_d;
    wr_en = (state_q == S_RESPOND) && op_write_q && !oob_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= 16'h0000;
      oob_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      oob_q      <= oob_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Array contents survive reset; a reset in the RESPOND cycle drops the write.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[addr_q] <= data_q;
    end
  end

  // Registered read port; the register only loads on a completing read, so
  // dataout holds across writes and idle periods.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataout_q <= 16'h0000;
    end else if (rd_en) begin
      dataout_q <= oob_d ? 16'h0000 : mem[addr_d];
    end
  end

  assign dataout = dataout_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign error   = error_q;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps

module tb_mem_responder;

  localparam int NDUT = 4;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [15:0] address;
  logic [15:0] datain;
  logic [15:0] dout [NDUT];
  logic        rdy  [NDUT];
  logic        bsy  [NDUT];
  logic        err  [NDUT];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  mem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .address(address), .datain(datain),
    .dataout(dout[0]), .ready(rdy[0]), .busy(bsy[0]), .error(err[0]));
  mem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .address(address), .datain(datain),
    .dataout(dout[1]), .ready(rdy[1]), .busy(bsy[1]), .error(err[1]));
  mem_responder #(.DEPTH_LOG2(8), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .address(address), .datain(datain),
    .dataout(dout[2]), .ready(rdy[2]), .busy(bsy[2]), .error(err[2]));
  mem_responder #(.DEPTH_LOG2(8), .LATENCY(15)) u_lat15 (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .address(address), .datain(datain),
    .dataout(dout[3]), .ready(rdy[3]), .busy(bsy[3]), .error(err[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int d);
    case (d)
      0: return 2;
      1: return 1;
      2: return 4;
      default: return 15;
    endcase
  endfunction

  // Reference model: each request is a transaction with an absolute accept
  // cycle; busy spans (accept, accept+L], ready fires at accept+L.
  bit          m_inflight [NDUT];
  int          m_ready_at [NDUT];
  bit          m_wr       [NDUT];
  logic [15:0] m_addr     [NDUT];
  logic [15:0] m_data     [NDUT];
  bit          m_oob      [NDUT];
  int          m_conf_at  [NDUT];
  logic [15:0] m_mem      [NDUT][256];
  bit          m_valid    [NDUT][256];
  bit          e_rdy      [NDUT];
  bit          e_bsy      [NDUT];
  bit          e_err      [NDUT];
  logic [15:0] e_dout     [NDUT];
  bit          e_dknown   [NDUT];
  int          rdy_count  [NDUT];

  bit          p_rd, p_wr, p_rst;
  logic [15:0] p_addr, p_din;

  task automatic chk(input string name, input int d, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lat=%0d cyc=%0d got=%h expected=%h", name, lat_of(d), cyc, got, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < NDUT; d++) begin
      int L;
      bit was_busy;
      L = lat_of(d);
      if (p_rst) begin
        m_inflight[d] = 1'b0;
        m_conf_at[d]  = -1;
        e_dout[d]     = 16'h0000;
        e_dknown[d]   = 1'b1;
      end else begin
        was_busy = m_inflight[d];
        if (was_busy && (cyc - 1) == m_ready_at[d]) begin
          if (m_wr[d] && !m_oob[d]) begin
            m_mem[d][m_addr[d][7:0]]   = m_data[d];
            m_valid[d][m_addr[d][7:0]] = 1'b1;
          end
          m_inflight[d] = 1'b0;
        end
        if (!was_busy) begin
          if (p_rd != p_wr) begin
            m_inflight[d] = 1'b1;
            m_ready_at[d] = cyc - 1 + L;
            m_wr[d]       = p_wr;
            m_addr[d]     = p_addr;
            m_data[d]     = p_din;
            m_oob[d]      = (p_addr[15:8] != 8'h00);
          end else if (p_rd && p_wr) begin
            m_conf_at[d] = cyc;
          end
        end
      end
      e_bsy[d] = m_inflight[d];
      e_rdy[d] = m_inflight[d] && (cyc == m_ready_at[d]);
      e_err[d] = !p_rst && ((m_conf_at[d] == cyc) || (e_rdy[d] && m_oob[d]));
      if (e_rdy[d] && !m_wr[d]) begin
        if (m_oob[d]) begin
          e_dout[d]   = 16'h0000;
          e_dknown[d] = 1'b1;
        end else begin
          e_dout[d]   = m_mem[d][m_addr[d][7:0]];
          e_dknown[d] = m_valid[d][m_addr[d][7:0]];
        end
      end
    end
  endtask

  // Advance one clock: capture the inputs of the ending cycle, update the
  // model, then compare every DUT against it just after the edge.
  task automatic tick();
    p_rd   = memread;
    p_wr   = memwrite;
    p_addr = address;
    p_din  = datain;
    p_rst  = reset;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("model_ready", d, {15'd0, rdy[d]}, {15'd0, e_rdy[d]});
      chk("model_busy",  d, {15'd0, bsy[d]}, {15'd0, e_bsy[d]});
      chk("model_error", d, {15'd0, err[d]}, {15'd0, e_err[d]});
      if (e_dknown[d]) chk("model_dataout", d, dout[d], e_dout[d]);
      if (rdy[d] === 1'b1) rdy_count[d]++;
    end
  endtask

  task automatic wait_idle();
    int guard;
    bit any;
    guard = 0;
    any = 1'b1;
    while (any && guard < 100) begin
      any = 1'b0;
      for (int d = 0; d < NDUT; d++) if (m_inflight[d]) any = 1'b1;
      if (any) begin
        tick();
        guard++;
      end
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle timeout cyc=%0d", cyc);
    end
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    wait_idle();
    memread  = rd;
    memwrite = wr;
    address  = a;
    datain   = d;
    tick();
    memread  = 1'b0;
    memwrite = 1'b0;
    wait_idle();
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] din;
    bit          x_rdy;
    bit          x_bsy;
    bit          x_err;
    logic [15:0] x_dout;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Write then read at LATENCY=2: row k = inputs in cycle k, outputs expected in cycle k.
    tbl[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'hBEEF};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF};

    for (int d = 0; d < NDUT; d++) begin
      m_inflight[d] = 1'b0;
      m_ready_at[d] = -1;
      m_conf_at[d]  = -1;
      e_dknown[d]   = 1'b0;
      e_dout[d]     = 16'h0000;
      rdy_count[d]  = 0;
      for (int a = 0; a < 256; a++) m_valid[d][a] = 1'b0;
    end

    reset    = 1'b1;
    memread  = 1'b0;
    memwrite = 1'b0;
    address  = 16'h0000;
    datain   = 16'h0000;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_dataout", d, dout[d], 16'h0000);
      chk("reset_ready",   d, {15'd0, rdy[d]}, 16'h0000);
      chk("reset_busy",    d, {15'd0, bsy[d]}, 16'h0000);
      chk("reset_error",   d, {15'd0, err[d]}, 16'h0000);
    end

    // Table-driven write/read sequence on the LATENCY=2 instance
    for (int i = 0; i < 7; i++) begin
      chk("tbl_ready", 0, {15'd0, rdy[0]}, {15'd0, tbl[i].x_rdy});
      chk("tbl_busy",  0, {15'd0, bsy[0]}, {15'd0, tbl[i].x_bsy});
      chk("tbl_error", 0, {15'd0, err[0]}, {15'd0, tbl[i].x_err});
      chk("tbl_dout",  0, dout[0], tbl[i].x_dout);
      memread  = tbl[i].rd;
      memwrite = tbl[i].wr;
      address  = tbl[i].addr;
      datain   = tbl[i].din;
      tick();
    end
    memread  = 1'b0;
    memwrite = 1'b0;
    wait_idle();

    // Conflicting request: error strobe only, no access
    do_req(1'b0, 1'b1, 16'h0005, 16'h1357);
    memread  = 1'b1;
    memwrite = 1'b1;
    address  = 16'h0005;
    datain   = 16'hFFFF;
    tick();
    memread  = 1'b0;
    memwrite = 1'b0;
    chk("conflict_error", 0, {15'd0, err[0]}, 16'h0001);
    chk("conflict_busy",  0, {15'd0, bsy[0]}, 16'h0000);
    chk("conflict_ready", 0, {15'd0, rdy[0]}, 16'h0000);
    tick();
    chk("conflict_error_clear", 0, {15'd0, err[0]}, 16'h0000);
    do_req(1'b1, 1'b0, 16'h0005, 16'h0000);
    chk("conflict_readback", 0, dout[0], 16'h1357);

    // Out-of-range write: ready and error together, word 0 untouched
    do_req(1'b0, 1'b1, 16'h0000, 16'h4321);
    memwrite = 1'b1;
    address  = 16'h0100;
    datain   = 16'h1234;
    tick();
    memwrite = 1'b0;
    chk("oob_busy", 0, {15'd0, bsy[0]}, 16'h0001);
    chk("oob_ready_early", 0, {15'd0, rdy[0]}, 16'h0000);
    tick();
    chk("oob_ready", 0, {15'd0, rdy[0]}, 16'h0001);
    chk("oob_error", 0, {15'd0, err[0]}, 16'h0001);
    do_req(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("oob_word0", 0, dout[0], 16'h4321);
    do_req(1'b1, 1'b0, 16'h0100, 16'h0000);
    chk("oob_read_zero", 0, dout[0], 16'h0000);

    // Reset mid-request aborts a pending write on every latency
    do_req(1'b0, 1'b1, 16'h0003, 16'h5555);
    memwrite = 1'b1;
    address  = 16'h0003;
    datain   = 16'hAAAA;
    tick();
    memwrite = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk("abort_busy",  d, {15'd0, bsy[d]}, 16'h0000);
      chk("abort_ready", d, {15'd0, rdy[d]}, 16'h0000);
    end
    do_req(1'b1, 1'b0, 16'h0003, 16'h0000);
    for (int d = 0; d < NDUT; d++) chk("abort_readback", d, dout[d], 16'h5555);

    // Request held high for 40 cycles, address wiggling while busy
    wait_idle();
    for (int d = 0; d < NDUT; d++) rdy_count[d] = 0;
    memread = 1'b1;
    for (int i = 0; i < 40; i++) begin
      address = 16'($urandom_range(0, 15));
      tick();
    end
    memread = 1'b0;
    wait_idle();
    for (int d = 0; d < NDUT; d++)
      chk("held_ready_count", d, 16'(rdy_count[d]), 16'(39 / (lat_of(d) + 1) + 1));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      memread  = ($urandom_range(0, 2) == 0);
      memwrite = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) address = {8'($urandom_range(1, 255)), 8'($urandom_range(0, 15))};
      else address = 16'($urandom_range(0, 15));
      datain = 16'($urandom);
      tick();
    end
    reset    = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    wait_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
